// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: two-requester arbiter sequencing CS/R/W accesses to one shared register
//   clk, rst_n                  : system clock, asynchronous active-low reset
//   a_req/a_we/a_wdata (and b_) : requester access request, write select, write data
//   a_gnt/a_ack/a_rdata (and b_): ownership, one-cycle completion pulse, captured read data
//   reg_d/reg_cs/reg_r/reg_w    : strobes and data driven to the shared register
//   reg_o                       : shared register output, valid while reg_cs && reg_r
//   REG_ARB_ROUND_ROBIN_EN      : define for round-robin tie-break, otherwise A wins every tie
module reg_access_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [WIDTH-1:0] a_wdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             a_gnt,
    output logic             a_ack,
    output logic [WIDTH-1:0] a_rdata,
    output logic             b_gnt,
    output logic             b_ack,
    output logic [WIDTH-1:0] b_rdata,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_cs,
    output logic             reg_r,
    output logic             reg_w,
    input  logic [WIDTH-1:0] reg_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state;
    logic sel_b;
    logic pick_b;
    logic pick_we;
    logic [WIDTH-1:0] pick_wd;
`ifdef REG_ARB_ROUND_ROBIN_EN
    logic last_b;
    // on a tie, hand the register to whoever was not granted last
    always_comb pick_b = b_req && (!a_req || !last_b);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_b <= 1'b1;
        else if (state == IDLE && (a_req || b_req))
            last_b <= pick_b;
    end
`else
    always_comb pick_b = b_req && !a_req;
`endif
    always_comb pick_we = pick_b ? b_we : a_we;
    always_comb pick_wd = pick_b ? b_wdata : a_wdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_b   <= 1'b0;
            reg_d   <= '0;
            reg_cs  <= 1'b0;
            reg_r   <= 1'b0;
            reg_w   <= 1'b0;
            a_gnt   <= 1'b0;
            b_gnt   <= 1'b0;
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (a_req || b_req) begin
                    state  <= ACCESS;
                    sel_b  <= pick_b;
                    reg_d  <= pick_wd;
                    reg_cs <= 1'b1;
                    reg_w  <= pick_we;
                    reg_r  <= !pick_we;
                    a_gnt  <= !pick_b;
                    b_gnt  <= pick_b;
                end
                ACCESS: begin
                    state  <= DONE;
                    reg_cs <= 1'b0;
                    reg_r  <= 1'b0;
                    reg_w  <= 1'b0;
                    a_ack  <= !sel_b;
                    b_ack  <= sel_b;
                    // reg_r still holds the latched read/write direction here
                    if (reg_r && sel_b)
                        b_rdata <= reg_o;
                    if (reg_r && !sel_b)
                        a_rdata <= reg_o;
                end
                DONE: begin
                    state <= IDLE;
                    a_gnt <= 1'b0;
                    b_gnt <= 1'b0;
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb_reg_access_arbiter: directed bench with a transaction-age model of the arbiter and a shared register
module tb_reg_access_arbiter;
`ifdef REG_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
    logic [15:0] a_wdata = '0, b_wdata = '0;
    logic a_gnt, b_gnt, a_ack, b_ack, reg_cs, reg_r, reg_w;
    logic [15:0] a_rdata, b_rdata, reg_d, reg_o;
    logic [15:0] mem = 16'h0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    reg_access_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata),
        .reg_d(reg_d), .reg_cs(reg_cs), .reg_r(reg_r), .reg_w(reg_w), .reg_o(reg_o)
    );
    // the shared register itself
    always @(posedge clk) if (reg_cs && reg_w) mem <= reg_d;
    assign reg_o = (reg_cs && reg_r) ? mem : 16'h0;
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    // model: age counts cycles since a request was accepted (1 = grant/strobe cycle, 2 = ack cycle, >=3 free)
    int age = 3;
    logic m_b = 1'b0, m_we = 1'b0, m_last = 1'b1, pick;
    logic [15:0] m_wd = '0, m_mem = '0, m_ra = '0, m_rb = '0;
    always_comb pick = b_req && (!a_req || (RR && !m_last));
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= 3;
            m_b <= 1'b0;
            m_we <= 1'b0;
            m_last <= 1'b1;
            m_wd <= '0;
            m_ra <= '0;
            m_rb <= '0;
        end else begin
            if (age == 1 && m_we) m_mem <= m_wd;
            if (age == 1 && !m_we && !m_b) m_ra <= m_mem;
            if (age == 1 && !m_we && m_b) m_rb <= m_mem;
            if (age >= 3 && (a_req || b_req)) begin
                age <= 1;
                m_b <= pick;
                m_we <= pick ? b_we : a_we;
                m_wd <= pick ? b_wdata : a_wdata;
                m_last <= pick;
            end else if (age < 3) age <= age + 1;
        end
    end
    always @(negedge clk) begin
        chk("a_gnt", a_gnt, (age == 1 || age == 2) && !m_b);
        chk("b_gnt", b_gnt, (age == 1 || age == 2) && m_b);
        chk("a_ack", a_ack, age == 2 && !m_b);
        chk("b_ack", b_ack, age == 2 && m_b);
        chk("reg_cs", reg_cs, age == 1);
        chk("reg_r", reg_r, age == 1 && !m_we);
        chk("reg_w", reg_w, age == 1 && m_we);
        chk("r_w_excl", reg_r && reg_w, 1'b0);
        chk("reg_d", reg_d, m_wd);
        chk("a_rdata", a_rdata, m_ra);
        chk("b_rdata", b_rdata, m_rb);
    end
    task automatic wait_ack(input bit b, input string nm, output int lat);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (b ? b_ack : a_ack) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: got no ack expected ack within 10 cycles", nm);
    endtask
    task automatic xact(input bit b, input bit we, input logic [15:0] wd, output logic [15:0] rd, output int lat);
        @(negedge clk);
        if (b) begin b_req = 1'b1; b_we = we; b_wdata = wd; end
        else begin a_req = 1'b1; a_we = we; a_wdata = wd; end
        wait_ack(b, "xact_ack", lat);
        rd = b ? b_rdata : a_rdata;
        if (b) b_req = 1'b0; else a_req = 1'b0;
    endtask
    initial begin
        logic [15:0] rd;
        logic [3:0] order;
        int lat, n, prev;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            a_req = ~a_req;
            b_req = ~b_req;
        end
        @(negedge clk);
        chk("rst_a_gnt", a_gnt, 1'b0);
        chk("rst_cs", reg_cs, 1'b0);
        chk("rst_rdata", b_rdata, 16'h0);
        a_req = 1'b0;
        b_req = 1'b0;
        #1 rst_n = 1'b1;
        xact(1'b0, 1'b1, 16'h00A5, rd, lat);
        chk("a_wr_latency", lat, 2);
        xact(1'b1, 1'b0, 16'h5A5A, rd, lat);
        chk("b_rd_data", rd, 16'h00A5);
        chk("b_rd_latency", lat, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
            a_wdata = 16'(i + 1); b_wdata = 16'(i + 1);
            lat = 0;
            while (!a_ack && !b_ack && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk("tie_ack_seen", a_ack || b_ack, 1'b1);
            order[i] = b_ack;
            a_req = 1'b0; b_req = 1'b0;
        end
        chk("tie_order", order, RR ? 4'b1010 : 4'b0000);
        xact(1'b0, 1'b0, 16'h0, rd, lat);
        chk("tie_last_write", rd, 16'h0004);
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_wdata = 16'h1234;
        @(negedge clk);
        b_req = 1'b0; b_wdata = 16'hDEAD;
        wait_ack(1'b1, "dropped_req_ack", lat);
        chk("dropped_req_lat", lat, 1);
        xact(1'b0, 1'b0, 16'h0, rd, lat);
        chk("dropped_req_data", rd, 16'h1234);
        xact(1'b0, 1'b1, 16'h0011, rd, lat);
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_wdata = 16'hFFFF;
        @(posedge clk);
        #2 rst_n = 1'b0;
        a_req = 1'b0;
        #1;
        chk("abort_cs", reg_cs, 1'b0);
        chk("abort_gnt", a_gnt, 1'b0);
        chk("abort_d", reg_d, 16'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        xact(1'b0, 1'b0, 16'h0, rd, lat);
        chk("abort_readback", rd, 16'h0011);
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_wdata = 16'h0;
        n = 0;
        prev = 0;
        for (int c = 1; c <= 20 && n < 3; c++) begin
            @(negedge clk);
            if (a_ack) begin
                if (n > 0) chk("b2b_spacing", c - prev, 3);
                chk("b2b_rdata", a_rdata, 16'h0011);
                prev = c;
                n++;
            end
        end
        a_req = 1'b0;
        chk("b2b_count", n, 3);
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_access_arbiter.md
# reg_access_arbiter

Two-port access controller for the 16-bit chip-selected register (D/O data, R, W, CS, CLK interface). Arbitrates between requester A and requester B, sequences the register's CS/R/W strobes for one read or write per grant, captures read data, and returns a one-cycle acknowledge. Sits between two bus masters and a single shared register instance, so neither master drives the register directly.

## Interface
- WIDTH, 16, data width of the shared register and both requester data paths.
- CLK  input  1  system clock; all state changes on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- A_REQ, B_REQ  input  1  access request; held high until matching ACK.
- A_WE, B_WE  input  1  1 = write, 0 = read; stable while REQ high.
- A_WDATA, B_WDATA  input  WIDTH  write data; stable while REQ high.
- A_GNT, B_GNT  output  1  requester owns the register (ACCESS and DONE states).
- A_ACK, B_ACK  output  1  one-cycle completion pulse.
- A_RDATA, B_RDATA  output  WIDTH  read data, valid in the ACK cycle, held until that requester's next read completes.
- REG_D  output  WIDTH  data to register D input.
- REG_CS, REG_R, REG_W  output  1  register chip-select, read enable, write enable.
- REG_O  input  WIDTH  register O output (valid only while CS and R high).

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state IDLE.
- IDLE: if any REQ high, select winner, latch its WE and WDATA, go ACCESS; else stay.
- ACCESS: GNT of winner high; REG_CS=1; REG_W=WE, REG_R=~WE; REG_D=latched WDATA. Write: register loads REG_D at the closing edge. Read: REG_O sampled at closing edge into winner's RDATA. Next state DONE.
- DONE: winner's GNT and ACK high, CS/R/W low. Next state IDLE.
- Arbitration: single request wins outright. Simultaneous requests resolved by last-grant pointer (see Configuration). Pointer updates on entry to ACCESS.
- REQ deasserted after being sampled: transaction still completes and ACK still pulses.
- REQ/WE/WDATA changes during ACCESS/DONE ignored (latched copy used).
- Non-winning requester's GNT, ACK, RDATA unaffected.
- REG_D holds last latched value outside ACCESS; REG_R and REG_W never both high; REG_R/REG_W never high without REG_CS.
- Reset values: state IDLE, all GNT/ACK 0, REG_CS/REG_R/REG_W 0, REG_D 0, A_RDATA/B_RDATA 0, last-grant pointer = B (A wins first tie).

## Timing
- All outputs registered; no combinational path from any input to any output.
- REQ sampled at edge k in IDLE -> GNT and CS/R/W high in cycle k+1 -> ACK high in cycle k+2 -> IDLE in k+3.
- Latency REQ-sampled to ACK: 2 cycles. Per-transaction occupancy: 3 cycles; REQ held continuously yields one ACK every 3 cycles.
- A write is visible on REG_O (with CS,R) from the DONE cycle onward.
- RST_N low at any time: outputs go to reset values immediately (asynchronously); in-flight transaction aborted, no ACK issued; aborted write does not commit if RST_N falls before the ACCESS closing edge.
- RST_N release: first REQ sampling at the first rising edge with RST_N high.

## Configuration
- REG_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester other than the last granted; a persistent two-way contention alternates A, B, A, B.
- REG_ARB_ROUND_ROBIN_EN undefined: fixed priority, A always wins ties; pointer logic absent; B can starve while A requests continuously.

## Test plan
- Reset: hold RST_N low, toggle REQs -> all GNT/ACK/CS/R/W = 0, RDATA = 0; release -> IDLE.
- A writes 16'h00A5, then B reads -> A_ACK at cycle k+2, then B_RDATA = 16'h00A5 in B_ACK cycle; REG_R and REG_W never simultaneously high.
- A_REQ and B_REQ high together for 4 transactions (alternating writes 1,2,3,4): with REG_ARB_ROUND_ROBIN_EN grant order A,B,A,B; without, A,A,A,A and B_GNT stays 0.
- B_REQ dropped in ACCESS cycle of a write of 16'h1234 -> B_ACK still pulses, register reads back 16'h1234.
- RST_N pulsed low mid-ACCESS of A write 16'hFFFF over stored 16'h0011 -> no A_ACK, CS low immediately, subsequent read returns 16'h0011.
- Back-to-back: A_REQ held for three reads -> A_ACK pulses exactly every 3 cycles, RDATA stable between pulses.
